pad_reader: RTL and testbench
=============================

// Module: pad_reader
// PURPOSE
//  Polls one NES-style serial gamepad (4021 shift-register protocol) once per frame and
//  drives the move_forward/move_backward inputs of the paddle stage. A poll starts on each
//  rising edge of vertical_sync, so button state is fresh and stable for the next paddle tick.
//  Also exports all 8 buttons for other game logic.
// PARAMETERS
//  PAD_CLK_DIV   4  pixel clocks per protocol tick (one half-period of pad_clock); >=4
//  LATCH_TICKS   2  protocol ticks that pad_latch is held high
//  FORWARD_BIT   5  button index mapped to move_forward (Down: paddle_y increases)
//  BACKWARD_BIT  4  button index mapped to move_backward (Up: paddle_y decreases)
// PORTS
//  pixel_clock    in   1  system clock; all logic on posedge
//  reset_n        in   1  asynchronous, active-low reset
//  vertical_sync  in   1  frame sync, pixel_clock domain; its rising edge starts a poll
//  pad_data       in   1  serial data from pad; active-low; asynchronous to pixel_clock
//  pad_latch      out  1  parallel-load strobe to pad; active-high
//  pad_clock      out  1  shift clock to pad; pad shifts on its rising edge
//  buttons        out  8  debounced-by-frame state; active-high; [0]=A,[1]=B,[2]=Sel,[3]=Start,[4]=Up,[5]=Down,[6]=Left,[7]=Right
//  buttons_valid  out  1  one-cycle pulse when buttons/move_* update
//  move_forward   out  1  to paddle move_forward
//  move_backward  out  1  to paddle move_backward
// BEHAVIOUR
//  Reset (async assert): FSM=IDLE; pad_latch=0, pad_clock=0, buttons=0, buttons_valid=0,
//   move_forward=0, move_backward=0; tick counter, bit counter, and shift register cleared;
//   synchronizer flops and last_vsync cleared. Deassertion mid-poll resumes in IDLE.
//  pad_data passes through a 2-flop synchronizer before use; all sampling uses the synced value.
//  Edge detect: last_vsync <= vertical_sync each cycle; start = vertical_sync & ~last_vsync.
//  Tick counter counts 0..PAD_CLK_DIV-1 while not IDLE; it is cleared on entry to LATCH.
//   "Tick end" = counter==PAD_CLK_DIV-1. Width is $clog2(PAD_CLK_DIV).
//  FSM states and transitions:
//   IDLE    -> LATCH on start. A start seen in any other state is ignored (no queueing).
//   LATCH   pad_latch=1. After LATCH_TICKS tick ends -> SETTLE.
//   SETTLE  pad_latch=0. At tick end: shift in ~pad_sync as bit0 -> HIGH.
//   HIGH    pad_clock=1. At tick end -> LOW.
//   LOW     pad_clock=0. At tick end: shift in the next bit; bit_cnt++.
//           If 8 bits are captured -> DONE, else -> HIGH.
//   DONE    One cycle: buttons <= shift register; buttons_valid=1; update move_* -> IDLE.
//  pad_latch and pad_clock are registered, glitch-free, and never high at the same time.
//  Exactly 7 pad_clock pulses occur per poll.
//  Latency: if start is seen in cycle N, pad_latch rises at N+1, and buttons_valid pulses at
//   N+1+(LATCH_TICKS+1+14)*PAD_CLK_DIV. With the defaults this is N+69.
//  Direction mapping: move_forward = buttons[FORWARD_BIT] & ~buttons[BACKWARD_BIT];
//   move_backward = buttons[BACKWARD_BIT] & ~buttons[FORWARD_BIT]. Both pressed drives both 0.
//   These are registered together with buttons.
//  Between DONE pulses, buttons and move_* hold their values.
//  No pad (pad_data floating high) reads as all buttons released.
// TESTING
//  1 Reset asserted mid-LATCH -> next cycle: pad_latch=0, pad_clock=0, all outputs 0, FSM IDLE;
//    no buttons_valid pulse until the next vsync rise.
//  2 4021 model loaded with A+Down (serial low at bits 0,5), vsync rise at cycle N ->
//    pad_latch high for N+1..N+8; 7 clock pulses; buttons_valid at N+69; buttons=8'h21;
//    move_forward=1, move_backward=0.
//  3 Up and Down both pressed -> buttons=8'h30; move_forward=0, move_backward=0.
//  4 Second vsync rise at N+20 (mid-poll) -> ignored; exactly one poll and one valid pulse;
//    next poll starts only on a later rise.
//  5 Up held for 3 frames then released -> move_backward=1 after polls 1-3; 0 after poll 4;
//    values stable between valid pulses.
//  6 pad_data tied high, PAD_CLK_DIV=6 -> buttons=0, and the valid pulse lands exactly at
//    N+1+17*6 = N+103.

Source files
------------

// File: rtl/pad_reader.sv
// Polls an NES-style 4021 serial gamepad once per frame (on each vertical_sync rise)
// and presents the 8 buttons plus the paddle move_forward/move_backward controls.
module pad_reader #(
    parameter int PAD_CLK_DIV  = 4,
    parameter int LATCH_TICKS  = 2,
    parameter int FORWARD_BIT  = 5,
    parameter int BACKWARD_BIT = 4
) (
    input  logic       pixel_clock,
    input  logic       reset_n,
    input  logic       vertical_sync,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clock,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       move_forward,
    output logic       move_backward
);

    localparam int TW = $clog2(PAD_CLK_DIV);
    localparam int LW = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        SETTLE = 3'd2,
        HIGH   = 3'd3,
        LOW    = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [LW-1:0] latch_cnt_q, latch_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        pad_meta_q, pad_sync_q;
    logic        last_vsync_q;
    logic        pad_latch_q, pad_latch_d;
    logic        pad_clock_q, pad_clock_d;
    logic [7:0]  buttons_q, buttons_d;
    logic        buttons_valid_q, buttons_valid_d;
    logic        move_forward_q, move_forward_d;
    logic        move_backward_q, move_backward_d;

    logic start;
    logic tick_end;

    assign start    = vertical_sync & ~last_vsync_q;
    assign tick_end = (tick_q == TW'(PAD_CLK_DIV - 1));

    always_comb begin
        state_d         = state_q;
        tick_d          = tick_q;
        latch_cnt_d     = latch_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        buttons_d       = buttons_q;
        move_forward_d  = move_forward_q;
        move_backward_d = move_backward_q;

        if (state_q != IDLE) begin
            tick_d = tick_end ? '0 : tick_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LATCH;
                    tick_d      = '0;
                    latch_cnt_d = '0;
                    bit_cnt_d   = '0;
                end
            end
            LATCH: begin
                if (tick_end) begin
                    if (latch_cnt_q == LW'(LATCH_TICKS - 1)) begin
                        state_d = SETTLE;
                    end else begin
                        latch_cnt_d = latch_cnt_q + LW'(1);
                    end
                end
            end
            SETTLE: begin
                // Pad data is active-low; the 4021 presents button A right after the latch.
                if (tick_end) begin
                    shift_d   = {~pad_sync_q, shift_q[7:1]};
                    bit_cnt_d = 3'd1;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (tick_end) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (tick_end) begin
                    shift_d   = {~pad_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d         = DONE;
                        buttons_d       = shift_d;
                        move_forward_d  = shift_d[FORWARD_BIT] & ~shift_d[BACKWARD_BIT];
                        move_backward_d = shift_d[BACKWARD_BIT] & ~shift_d[FORWARD_BIT];
                    end else begin
                        state_d = HIGH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes decode the next state so they come straight from flops.
        pad_latch_d     = (state_d == LATCH);
        pad_clock_d     = (state_d == HIGH);
        buttons_valid_d = (state_d == DONE);
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            tick_q          <= '0;
            latch_cnt_q     <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            pad_meta_q      <= 1'b0;
            pad_sync_q      <= 1'b0;
            last_vsync_q    <= 1'b0;
            pad_latch_q     <= 1'b0;
            pad_clock_q     <= 1'b0;
            buttons_q       <= '0;
            buttons_valid_q <= 1'b0;
            move_forward_q  <= 1'b0;
            move_backward_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            tick_q          <= tick_d;
            latch_cnt_q     <= latch_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            pad_meta_q      <= pad_data;
            pad_sync_q      <= pad_meta_q;
            last_vsync_q    <= vertical_sync;
            pad_latch_q     <= pad_latch_d;
            pad_clock_q     <= pad_clock_d;
            buttons_q       <= buttons_d;
            buttons_valid_q <= buttons_valid_d;
            move_forward_q  <= move_forward_d;
            move_backward_q <= move_backward_d;
        end
    end

    assign pad_latch     = pad_latch_q;
    assign pad_clock     = pad_clock_q;
    assign buttons       = buttons_q;
    assign buttons_valid = buttons_valid_q;
    assign move_forward  = move_forward_q;
    assign move_backward = move_backward_q;

endmodule

// File: tb/tb_pad_reader.sv
// Directed bench for pad_reader: a 4021 gamepad model drives the default-parameter
// instance; a second instance with PAD_CLK_DIV=6 sees a floating (high) pad line.
module tb_pad_reader;

    logic       clk;
    logic       reset_n;
    logic       vsync;
    logic       vsync6;
    logic       pad_hi;
    wire        pad_data;
    logic       pad_latch, pad_clock, buttons_valid, move_forward, move_backward;
    logic [7:0] buttons;
    logic       pad_latch6, pad_clock6, buttons_valid6, move_forward6, move_backward6;
    logic [7:0] buttons6;

    logic [7:0] pad_buttons;   // pressed = 1
    logic [7:0] pad_sr;
    logic       pc_prev_model;

    int n_pass;
    int n_fail;
    int n_total;

    logic [7:0] prev_btn;
    logic       prev_f;
    logic       prev_b;

    pad_reader u_dut (
        .pixel_clock  (clk),
        .reset_n      (reset_n),
        .vertical_sync(vsync),
        .pad_data     (pad_data),
        .pad_latch    (pad_latch),
        .pad_clock    (pad_clock),
        .buttons      (buttons),
        .buttons_valid(buttons_valid),
        .move_forward (move_forward),
        .move_backward(move_backward)
    );

    pad_reader #(.PAD_CLK_DIV(6)) u_dut6 (
        .pixel_clock  (clk),
        .reset_n      (reset_n),
        .vertical_sync(vsync6),
        .pad_data     (pad_hi),
        .pad_latch    (pad_latch6),
        .pad_clock    (pad_clock6),
        .buttons      (buttons6),
        .buttons_valid(buttons_valid6),
        .move_forward (move_forward6),
        .move_backward(move_backward6)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    // 4021 model: parallel load while latched, shift on pad_clock rise, output active-low
    always @(posedge clk) begin
        if (pad_latch) pad_sr <= pad_buttons;
        else if (pad_clock && !pc_prev_model) pad_sr <= {1'b0, pad_sr[7:1]};
        pc_prev_model <= pad_clock;
    end
    assign pad_data = ~pad_sr[0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_poll(input string name, input logic [7:0] load, input logic [7:0] exp_btn,
                            input logic exp_f, input logic exp_b, input int second_k);
        int valid_k, n_valid, n_pulse, latch_first, latch_n;
        logic overlap, prev_pc, stable_ok;
        valid_k = 0; n_valid = 0; n_pulse = 0; latch_first = 0; latch_n = 0;
        overlap = 1'b0; prev_pc = 1'b0; stable_ok = 1'b1;
        pad_buttons = load;
        @(negedge clk) vsync = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            if (k == 2) vsync = 1'b0;
            if (second_k > 0 && k == second_k) vsync = 1'b1;
            if (second_k > 0 && k == second_k + 2) vsync = 1'b0;
            if (pad_latch) begin
                latch_n++;
                if (latch_first == 0) latch_first = k;
            end
            if (pad_clock && !prev_pc) n_pulse++;
            prev_pc = pad_clock;
            if (pad_latch && pad_clock) overlap = 1'b1;
            if (buttons_valid) begin
                n_valid++;
                if (valid_k == 0) valid_k = k;
            end else if (valid_k == 0) begin
                if (buttons !== prev_btn || move_forward !== prev_f || move_backward !== prev_b)
                    stable_ok = 1'b0;
            end else begin
                if (buttons !== exp_btn || move_forward !== exp_f || move_backward !== exp_b)
                    stable_ok = 1'b0;
            end
        end
        check({name, ".latch_first"}, latch_first, 1);
        check({name, ".latch_cycles"}, latch_n, 8);
        check({name, ".clk_pulses"}, n_pulse, 7);
        check({name, ".no_overlap"}, {31'd0, overlap}, 0);
        check({name, ".valid_at"}, valid_k, 69);
        check({name, ".valid_count"}, n_valid, 1);
        check({name, ".buttons"}, {24'd0, buttons}, {24'd0, exp_btn});
        check({name, ".move_fwd"}, {31'd0, move_forward}, {31'd0, exp_f});
        check({name, ".move_bwd"}, {31'd0, move_backward}, {31'd0, exp_b});
        check({name, ".stable"}, {31'd0, stable_ok}, 1);
        prev_btn = exp_btn;
        prev_f   = exp_f;
        prev_b   = exp_b;
    endtask

    initial begin
        int quiet_bad, valid_k, latch_n, n_pulse;
        logic prev_pc;
        n_pass = 0; n_fail = 0; n_total = 0;
        reset_n = 1'b0; vsync = 1'b0; vsync6 = 1'b0; pad_hi = 1'b1;
        pad_buttons = 8'h00; pad_sr = 8'h00; pc_prev_model = 1'b0;
        prev_btn = 8'h00; prev_f = 1'b0; prev_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.pad_latch", {31'd0, pad_latch}, 0);
        check("rst.pad_clock", {31'd0, pad_clock}, 0);
        check("rst.buttons", {24'd0, buttons}, 0);
        check("rst.valid", {31'd0, buttons_valid}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // A + Down
        run_poll("a_down", 8'h21, 8'h21, 1'b1, 1'b0, 0);

        // Reset asserted in the middle of LATCH
        pad_buttons = 8'h21;
        @(negedge clk) vsync = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        check("midrst.latch_before", {31'd0, pad_latch}, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst.pad_latch", {31'd0, pad_latch}, 0);
        check("midrst.pad_clock", {31'd0, pad_clock}, 0);
        check("midrst.buttons", {24'd0, buttons}, 0);
        check("midrst.valid", {31'd0, buttons_valid}, 0);
        check("midrst.move", {30'd0, move_forward, move_backward}, 0);
        @(negedge clk) reset_n = 1'b1;
        quiet_bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (buttons_valid || pad_latch || pad_clock) quiet_bad++;
        end
        check("midrst.quiet", quiet_bad, 0);
        prev_btn = 8'h00; prev_f = 1'b0; prev_b = 1'b0;

        // Up + Down together cancel
        run_poll("up_down", 8'h30, 8'h30, 1'b0, 1'b0, 0);

        // Extra vsync rise mid-poll is ignored
        run_poll("midpoll_vs", 8'h21, 8'h21, 1'b1, 1'b0, 20);

        // Up held for three frames, then released
        run_poll("up_f1", 8'h10, 8'h10, 1'b0, 1'b1, 0);
        run_poll("up_f2", 8'h10, 8'h10, 1'b0, 1'b1, 0);
        run_poll("up_f3", 8'h10, 8'h10, 1'b0, 1'b1, 0);
        run_poll("up_rel", 8'h00, 8'h00, 1'b0, 1'b0, 0);

        // No pad with PAD_CLK_DIV=6
        valid_k = 0; latch_n = 0; n_pulse = 0; prev_pc = 1'b0;
        @(negedge clk) vsync6 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (k == 2) vsync6 = 1'b0;
            if (pad_latch6) latch_n++;
            if (pad_clock6 && !prev_pc) n_pulse++;
            prev_pc = pad_clock6;
            if (buttons_valid6 && valid_k == 0) valid_k = k;
        end
        check("div6.valid_at", valid_k, 103);
        check("div6.latch_cycles", latch_n, 12);
        check("div6.clk_pulses", n_pulse, 7);
        check("div6.buttons", {24'd0, buttons6}, 0);
        check("div6.move", {30'd0, move_forward6, move_backward6}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
